// File: rtl/ncsp_mash_combiner.sv
// MASH 1-1-1 noise-cancellation combiner: forms the cancellation offset from the
// three quantizer carries, adds the integer divide value and emits a clipped ratio.
module ncsp_mash_combiner #(
    parameter int P_N_WIDTH = 8,
    parameter int P_DIV_MIN = 8,
    parameter int P_DIV_MAX = 255,
    parameter int P_WARMUP  = 8
) (
    input  logic                 i_clk,
    input  logic                 i_ff_rst,
    input  logic                 i_en,
    input  logic                 i_quantize1,
    input  logic                 i_quantize2,
    input  logic                 i_quantize3,
    input  logic [P_N_WIDTH-1:0] i_int_n,
    input  logic                 i_int_load,
    input  logic                 i_clr_cnt,
    output logic [P_N_WIDTH-1:0] o_div_ratio,
    output logic                 o_div_valid,
    output logic [3:0]           o_offset,
    output logic                 o_clip,
    output logic [7:0]           o_clip_cnt
);

    localparam int SW = P_N_WIDTH + 2;
    localparam logic [7:0]           WARM_LAST = 8'(P_WARMUP - 1);
    localparam logic signed [SW-1:0] DIV_MIN_S = SW'(P_DIV_MIN);
    localparam logic signed [SW-1:0] DIV_MAX_S = SW'(P_DIV_MAX);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WARMUP,
        S_RUN
    } state_t;

    state_t state_q, state_d;
    logic [7:0] wcnt_q, wcnt_d;

    logic [2:0] q_in;
    logic [2:0] smp_q, smp_d;   // q[k]
    logic [2:0] h1_q, h1_d;     // q[k-1]
    logic [2:0] h2_q, h2_d;     // q[k-2]
    logic       shift_en;

    logic [3:0] off_q, off_d;
    logic [3:0] off_sum;
    logic       sval_q, sval_d;
    logic       v1_q, v1_d;

    logic [P_N_WIDTH-1:0] n_act_q, n_act_d;
    logic [P_N_WIDTH-1:0] ratio_q, ratio_d;
    logic                 valid_q, valid_d;
    logic                 clip_q, clip_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [SW-1:0]        off_ext;
    logic [SW-1:0]        sum;

    // State machine: dropping i_en wins over every other transition
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        if (!i_en) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_WARMUP;
                    wcnt_d  = 8'd0;
                end
                S_WARMUP: begin
                    if (wcnt_q == WARM_LAST) begin
                        state_d = S_RUN;
                    end else begin
                        wcnt_d = wcnt_q + 8'd1;
                    end
                end
                S_RUN:   state_d = S_RUN;
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign shift_en = i_en && (state_q != S_IDLE);
    assign q_in     = {i_quantize3, i_quantize2, i_quantize1};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_hist
            assign smp_d[gi] = shift_en & q_in[gi];
            assign h1_d[gi]  = shift_en & smp_q[gi];
            assign h2_d[gi]  = shift_en & h1_q[gi];
        end
    endgenerate

    // 4-bit modular sum is exact two's complement since the result lies in -3..+4
    always_comb begin
        off_sum = {3'b000, h2_q[0]}
                + {3'b000, h1_q[1]} - {3'b000, h2_q[1]}
                + {3'b000, smp_q[2]} - {2'b00, h1_q[2], 1'b0} + {3'b000, h2_q[2]};
        off_d   = shift_en ? off_sum : 4'd0;
        sval_d  = (state_d == S_RUN);
        v1_d    = i_en & sval_q;
        valid_d = i_en & v1_q;
        n_act_d = i_int_load ? i_int_n : n_act_q;
    end

    // Outside an active sequence the ratio is the bare integer value
    always_comb begin
        off_ext = shift_en ? {{(SW-4){off_q[3]}}, off_q} : '0;
        sum     = {2'b00, n_act_q} + off_ext;
        ratio_d = sum[P_N_WIDTH-1:0];
        clip_d  = 1'b0;
        if ($signed(sum) < DIV_MIN_S) begin
            ratio_d = P_N_WIDTH'(P_DIV_MIN);
            clip_d  = 1'b1;
        end else if ($signed(sum) > DIV_MAX_S) begin
            ratio_d = P_N_WIDTH'(P_DIV_MAX);
            clip_d  = 1'b1;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr_cnt) begin
            cnt_d = 8'd0;
        end else if (clip_d && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_ff_rst) begin
            state_q <= S_IDLE;
            wcnt_q  <= 8'd0;
            smp_q   <= 3'b000;
            h1_q    <= 3'b000;
            h2_q    <= 3'b000;
            off_q   <= 4'd0;
            sval_q  <= 1'b0;
            v1_q    <= 1'b0;
            n_act_q <= '0;
            ratio_q <= '0;
            valid_q <= 1'b0;
            clip_q  <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            smp_q   <= smp_d;
            h1_q    <= h1_d;
            h2_q    <= h2_d;
            off_q   <= off_d;
            sval_q  <= sval_d;
            v1_q    <= v1_d;
            n_act_q <= n_act_d;
            ratio_q <= ratio_d;
            valid_q <= valid_d;
            clip_q  <= clip_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_div_ratio = ratio_q;
    assign o_div_valid = valid_q;
    assign o_offset    = off_q;
    assign o_clip      = clip_q;
    assign o_clip_cnt  = cnt_q;

endmodule

// File: doc/ncsp_mash_combiner.md
# ncsp_mash_combiner

Noise-cancellation and divide-ratio stage placed directly downstream of the NCSP MASH core. It takes the three per-cycle quantizer bits, forms the MASH 1-1-1 cancellation offset (range −3…+4), adds the programmed integer divide value and produces a clipped, registered divide ratio for the multi-modulus divider. It also runs a warm-up sequence after enable so the divider never sees an offset built from partially filled history, and it counts clip events.

## Interface
- P_N_WIDTH, 8, width of the integer divide value and the output ratio
- P_DIV_MIN, 8, smallest ratio the divider accepts; lower results clip here
- P_DIV_MAX, 255, largest ratio the divider accepts; higher results clip here
- P_WARMUP, 8, cycles spent in WARMUP before RUN; legal values are 2…255
- i_clk  in  1  divider-side clock; all state changes on its rising edge
- i_ff_rst  in  1  synchronous, active-high reset
- i_en  in  1  run enable
- i_quantize1  in  1  MASH stage-1 carry
- i_quantize2  in  1  MASH stage-2 carry
- i_quantize3  in  1  MASH stage-3 carry
- i_int_n  in  P_N_WIDTH  integer divide value (unsigned)
- i_int_load  in  1  one-cycle strobe that captures i_int_n
- i_clr_cnt  in  1  clears o_clip_cnt
- o_div_ratio  out  P_N_WIDTH  registered divide ratio
- o_div_valid  out  1  high when o_div_ratio carries a full-history result
- o_offset  out  4  registered signed cancellation offset (two's complement)
- o_clip  out  1  one-cycle pulse when the current o_div_ratio was clipped
- o_clip_cnt  out  8  saturating clip-event counter

## Operation
- **State machine:** IDLE, WARMUP, RUN.
  - IDLE → WARMUP when i_en = 1. The warm-up counter resets to 0.
  - WARMUP → RUN when i_en = 1 and the counter equals P_WARMUP−1. Otherwise the counter increments.
  - Any state → IDLE when i_en = 0. This takes priority.
- **History:** two-deep shift registers per quantizer, holding q[k−1] and q[k−2].
  - They shift every cycle in WARMUP and RUN.
  - They are forced to 0 in IDLE and on reset.
- **Offset:** computed from the bits sampled at edge k, q[k]:
  - off = q1[k−2] + (q2[k−1] − q2[k−2]) + (q3[k] − 2·q3[k−1] + q3[k−2])
  - Computed in 4-bit signed arithmetic; the result range is −3…+4.
- **Ratio:** sum = N_act + off, computed in P_N_WIDTH+2 signed arithmetic.
  - If sum < P_DIV_MIN, the ratio is P_DIV_MIN.
  - If sum > P_DIV_MAX, the ratio is P_DIV_MAX.
  - Otherwise the ratio is sum.
- **N_act:** loaded from i_int_n on any edge where i_int_load = 1, in every state.
- **In IDLE:** o_div_ratio tracks N_act with zero offset, o_offset = 0 and o_div_valid = 0.
- **Clip counting:** o_clip_cnt increments on each o_clip pulse and saturates at 255.
  - i_clr_cnt clears it.
  - If i_clr_cnt and o_clip occur on the same edge, the counter becomes 0.

## Timing
- **Pipeline:**
  - Edge k samples q[k] and shifts the history.
  - Edge k+1 registers the offset derived from q[k] into the stage-1 register and o_offset.
  - Edge k+2 registers o_div_ratio, using that offset and the N_act value present at edge k+2. o_clip is updated on the same edge.
- **Latency:** quantizer bits to o_div_ratio is 2 cycles. An i_int_load strobe at edge j appears in o_div_ratio at edge j+1.
- **o_div_valid:** follows the "state was RUN when the sample was taken" flag through the same 2-stage pipeline. It therefore first rises 2 edges after the state enters RUN and stays high continuously while in RUN.
- **i_en dropping mid-run:** on the next edge the state is IDLE, both pipeline valid flags clear, o_div_valid goes low and o_offset goes to 0. No partial results are emitted.
- **Reset values:** state IDLE, history 0, N_act 0, o_div_ratio 0, o_offset 0, o_div_valid 0, o_clip 0, o_clip_cnt 0. Reset overrides i_en, i_int_load and i_clr_cnt.
- **Re-entry:** re-entering WARMUP from IDLE always runs the full P_WARMUP cycles.

## Test plan
- **Static:** reset, load N=20, i_en=1, all q=0 → o_div_valid rises at warm-up end + 2 cycles; o_div_ratio stays 20 and o_offset stays 0.
- **q1 only:** q1 held at 1, q2=q3=0, N=20 → o_div_ratio = 21 in steady state.
- **q3 impulse:** single q3=1 at sample k, others 0, N=20 → ratios 21, 18, 21 at edges k+2, k+3, k+4, then 20. o_offset shows +1, −2, +1.
- **Clip:** P_DIV_MIN=8, N=8, q3 impulse → ratios 9, 8 (clipped), 9. o_clip pulses once and o_clip_cnt = 1. A simultaneous i_clr_cnt leaves the count at 0.
- **Live N change:** in RUN with q=0, load N=30 at edge j → o_div_ratio = 30 from edge j+1, and o_div_valid stays high.
- **Abort:** drop i_en during RUN → o_div_valid is low on the next edge. Re-raise i_en → P_WARMUP cycles pass, then valid returns. Asserting i_ff_rst mid-WARMUP returns all outputs to their reset values on the next edge.
